alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Sequential execution wrapper around the 16-bit combinational ALU: accepts commands over a valid/ready handshake, reads operands from a 4×16-bit register file (or an immediate), drives the ALU for one cycle, writes the result back, and presents it on a valid/ready result port. It sits directly upstream and downstream of the ALU. The ALU is instantiated externally and connected through the `alu_*` ports. Carry and overflow flags are kept so that multi-word add chains are possible.

## Interface
- `N`, 16, datapath width (matches ALU).
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  unit can accept a command.
- `cmd_mode`  in  4  ALU mode, 0–15.
- `cmd_ra`, `cmd_rb`, `cmd_rd`  in  2 each  source A, source B, destination register index.
- `cmd_imm_sel`  in  1  1: B operand = `cmd_imm`; 0: B = reg[`cmd_rb`].
- `cmd_imm`  in  N  immediate.
- `cmd_cin_sel`  in  1  1: Cin = carry flag C; 0: Cin = 0.
- `cmd_we`  in  1  write result to reg[`cmd_rd`].
- `alu_A`, `alu_B`  out  N  registered ALU operands.
- `alu_Mode`  out  4  registered ALU mode.
- `alu_Cin`  out  1  registered ALU carry-in.
- `alu_Y`  in  N  ALU result.
- `alu_Cout`, `alu_Overflow`  in  1 each  ALU flags.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  N  captured `alu_Y`.
- `res_cout`, `res_ovf`  out  1 each  captured `alu_Cout`, `alu_Overflow`.
- `flag_c`, `flag_v`  out  1 each  current carry and overflow flags.

## Operation
- FSM states:
  - IDLE → EXEC on `cmd_valid & cmd_ready`.
  - EXEC → RESP unconditionally.
  - RESP → IDLE on `res_ready`.
- `cmd_ready` = (state == IDLE). It is combinational, and there is no command buffering.
- Command acceptance (IDLE edge) latches:
  - `alu_A` ← reg[ra].
  - `alu_B` ← imm_sel ? imm : reg[rb].
  - `alu_Mode` ← mode.
  - `alu_Cin` ← cin_sel & C.
  - rd and we are latched internally.
- Register reads use the register-file contents before that edge. No result is ever pending at acceptance, so no hazard exists.
- EXEC edge:
  - `res_data`/`res_cout`/`res_ovf` ← `alu_Y`/`alu_Cout`/`alu_Overflow`.
  - If we, reg[rd] ← `alu_Y`.
  - If mode is 4 or 5, C ← `alu_Cout` and V ← `alu_Overflow`. Other modes leave the flags unchanged.
- RESP: `res_valid` = 1. `res_*` are held stable until the handshake completes. `res_valid` drops on the edge where `res_ready` = 1.
- `alu_*` outputs hold their last values outside EXEC; they are never cleared by completion.
- A load-immediate uses mode 14 with imm_sel = 1. A compare without writeback uses mode 13 with we = 0.
- cmd_rd may equal ra or rb. Operands were latched at acceptance, so the write in EXEC is safe.
- Reset (asynchronous, any state, including mid-EXEC or mid-RESP):
  - state = IDLE; reg[0..3] = 0; C = V = 0.
  - `alu_A` = `alu_B` = 0, `alu_Mode` = 0, `alu_Cin` = 0.
  - `res_valid` = 0, `res_data` = 0, `res_cout` = `res_ovf` = 0.
  - An in-flight command is discarded with no writeback.
- `cmd_ready` is 1 while in IDLE, but no command is accepted on an edge where `rst` is high.

## Timing
- Command accepted at edge k. ALU inputs are valid after edge k. Combinational ALU evaluation occurs during cycle k+1.
- Result, writeback and flags are registered at edge k+1. `res_valid` = 1 from edge k+1.
- Minimum command-to-command spacing is 3 cycles (IDLE, EXEC, RESP with `res_ready` held high).
- `res_ready` asserted early (before RESP) has no effect. Only `res_ready` sampled while in RESP completes the transfer.
- The ALU path must close timing within one clock cycle between the registered `alu_*` outputs and the capture registers.

## Test plan
- **Reset values:** assert `rst` asynchronously mid-cycle → all outputs go to their reset values immediately; `cmd_ready` = 1 after release; reg reads return 0.
- **Add with overflow:**
  - Load r0 = 0x7FFF and r1 = 0x0001 (mode 14, imm).
  - Issue mode 4, ra = 0, rb = 1, rd = 2 → `res_data` = 0x8000, `res_ovf` = 1, `res_cout` = 0, `flag_v` = 1.
  - A subsequent read of r2 gives 0x8000.
- **Carry chain:**
  - r0 = 0xFFFF plus imm 0x0001 → `res_data` = 0x0000, C = 1.
  - Next: mode 4, r1 = 0x0000 + imm 0x0000 with cin_sel = 1 → `res_data` = 0x0001.
- **Subtract and flag retention:**
  - r0 = 5, imm 3, mode 5 → `res_data` = 0x0002, `res_cout` = 1.
  - Then mode 6 (AND) → `flag_c` stays 1.
- **Result backpressure:** hold `res_ready` = 0 for 5 cycles with `cmd_valid` = 1 → `cmd_ready` stays 0, `res_data` stays stable, and no second command is accepted. Release `res_ready` → handshake completes, and the next command is accepted one cycle later.
- **Compare without write and reset mid-EXEC:**
  - Mode 13, r0 = 1, imm 2, we = 0 → `res_data` = 1, r3 unchanged.
  - Assert `rst` during EXEC of a write to r3 → r3 = 0 and `res_valid` never rises.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Bus bundle for alu_exec_unit: command handshake, registered ALU drive/return, result handshake and flags.
// The slave side is the execution unit; the master side is the surrounding system plus the external ALU.
interface alu_exec_unit_if #(
  parameter int N = 16
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_mode;
  logic [1:0]   cmd_ra;
  logic [1:0]   cmd_rb;
  logic [1:0]   cmd_rd;
  logic         cmd_imm_sel;
  logic [N-1:0] cmd_imm;
  logic         cmd_cin_sel;
  logic         cmd_we;

  logic [N-1:0] alu_A;
  logic [N-1:0] alu_B;
  logic [3:0]   alu_Mode;
  logic         alu_Cin;
  logic [N-1:0] alu_Y;
  logic         alu_Cout;
  logic         alu_Overflow;

  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic         res_cout;
  logic         res_ovf;

  logic         flag_c;
  logic         flag_v;

  modport slave (
    input  cmd_valid, cmd_mode, cmd_ra, cmd_rb, cmd_rd, cmd_imm_sel, cmd_imm, cmd_cin_sel, cmd_we,
    output cmd_ready,
    output alu_A, alu_B, alu_Mode, alu_Cin,
    input  alu_Y, alu_Cout, alu_Overflow,
    output res_valid, res_data, res_cout, res_ovf,
    input  res_ready,
    output flag_c, flag_v
  );

  modport master (
    output cmd_valid, cmd_mode, cmd_ra, cmd_rb, cmd_rd, cmd_imm_sel, cmd_imm, cmd_cin_sel, cmd_we,
    input  cmd_ready,
    input  alu_A, alu_B, alu_Mode, alu_Cin,
    output alu_Y, alu_Cout, alu_Overflow,
    input  res_valid, res_data, res_cout, res_ovf,
    output res_ready,
    input  flag_c, flag_v
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Sequential wrapper around an external 16-bit ALU: accept, execute for one cycle, write back, respond.
// Holds a 4x16 register file and the C/V flags used for multi-word add/subtract chains.
module alu_exec_unit #(
  parameter int N = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_exec_unit_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]   state;
  logic [N-1:0] regs [4];
  logic         flag_c_q;
  logic         flag_v_q;
  logic [N-1:0] alu_a_q;
  logic [N-1:0] alu_b_q;
  logic [3:0]   alu_mode_q;
  logic         alu_cin_q;
  logic [1:0]   rd_q;
  logic         we_q;
  logic [N-1:0] res_data_q;
  logic         res_cout_q;
  logic         res_ovf_q;

  // Operands are read from the register file as it stood before the accepting edge;
  // nothing can be pending then, so rd aliasing ra/rb needs no forwarding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      flag_c_q   <= 1'b0;
      flag_v_q   <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_mode_q <= 4'd0;
      alu_cin_q  <= 1'b0;
      rd_q       <= 2'd0;
      we_q       <= 1'b0;
      res_data_q <= '0;
      res_cout_q <= 1'b0;
      res_ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            alu_a_q    <= regs[bus.cmd_ra];
            alu_b_q    <= bus.cmd_imm_sel ? bus.cmd_imm : regs[bus.cmd_rb];
            alu_mode_q <= bus.cmd_mode;
            alu_cin_q  <= bus.cmd_cin_sel & flag_c_q;
            rd_q       <= bus.cmd_rd;
            we_q       <= bus.cmd_we;
            state      <= EXEC;
          end
        end
        EXEC: begin
          res_data_q <= bus.alu_Y;
          res_cout_q <= bus.alu_Cout;
          res_ovf_q  <= bus.alu_Overflow;
          if (we_q) regs[rd_q] <= bus.alu_Y;
          // Only add (4) and subtract (5) produce meaningful carry/overflow for chaining.
          if (alu_mode_q == 4'd4 || alu_mode_q == 4'd5) begin
            flag_c_q <= bus.alu_Cout;
            flag_v_q <= bus.alu_Overflow;
          end
          state <= RESP;
        end
        RESP: begin
          if (bus.res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.res_valid = (state == RESP);
  assign bus.res_data  = res_data_q;
  assign bus.res_cout  = res_cout_q;
  assign bus.res_ovf   = res_ovf_q;
  assign bus.alu_A     = alu_a_q;
  assign bus.alu_B     = alu_b_q;
  assign bus.alu_Mode  = alu_mode_q;
  assign bus.alu_Cin   = alu_cin_q;
  assign bus.flag_c    = flag_c_q;
  assign bus.flag_v    = flag_v_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: a stand-in combinational ALU plus a transaction-level model
// (register array, C/V flags) checked over directed scenarios and randomized command streams.
module tb_alu_exec_unit;

  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;

  alu_exec_unit_if #(.N(16)) bus ();

  alu_exec_unit #(.N(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU, returns {cout, ovf, y}. Modes other than add/sub report arbitrary
  // flag bits so that flag retention on those modes is actually exercised.
  function automatic logic [17:0] aluModel(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] m, input logic cin);
    logic [16:0] s;
    logic [15:0] y;
    logic        co;
    logic        ov;
    s = '0;
    y = '0;
    co = 1'b0;
    ov = 1'b0;
    case (m)
      4'd0:  y = a;
      4'd1:  y = a + 16'd1;
      4'd2:  y = a - 16'd1;
      4'd3:  y = b;
      4'd4: begin
        s  = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        y  = s[15:0];
        co = s[16];
        ov = (a[15] == b[15]) && (y[15] != a[15]);
      end
      4'd5: begin
        s  = {1'b0, a} - {1'b0, b} - {16'd0, cin};
        y  = s[15:0];
        co = ~s[16];
        ov = (a[15] != b[15]) && (y[15] != a[15]);
      end
      4'd6:  y = a & b;
      4'd7:  y = a | b;
      4'd8:  y = a ^ b;
      4'd9:  y = ~a;
      4'd10: y = a << 1;
      4'd11: y = a >> 1;
      4'd12: y = {15'd0, a == b};
      4'd13: y = {15'd0, a < b};
      4'd14: y = b;
      default: y = a;
    endcase
    if (m != 4'd4 && m != 4'd5) begin
      co = y[15];
      ov = y[0];
    end
    return {co, ov, y};
  endfunction

  assign {bus.alu_Cout, bus.alu_Overflow, bus.alu_Y} =
    aluModel(bus.alu_A, bus.alu_B, bus.alu_Mode, bus.alu_Cin);

  logic [15:0] modelRegs [4];
  logic        modelC;
  logic        modelV;

  task automatic modelReset();
    for (int i = 0; i < 4; i++) modelRegs[i] = 16'd0;
    modelC = 1'b0;
    modelV = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_res_valid"}, bus.res_valid, 0);
    checkOutput({tag, "_res_data"},  bus.res_data, 0);
    checkOutput({tag, "_res_cout"},  bus.res_cout, 0);
    checkOutput({tag, "_res_ovf"},   bus.res_ovf, 0);
    checkOutput({tag, "_alu_A"},     bus.alu_A, 0);
    checkOutput({tag, "_alu_B"},     bus.alu_B, 0);
    checkOutput({tag, "_alu_Mode"},  bus.alu_Mode, 0);
    checkOutput({tag, "_alu_Cin"},   bus.alu_Cin, 0);
    checkOutput({tag, "_flag_c"},    bus.flag_c, 0);
    checkOutput({tag, "_flag_v"},    bus.flag_v, 0);
    checkOutput({tag, "_cmd_ready"}, bus.cmd_ready, 1);
  endtask

  task automatic driveCmd(input logic [3:0] mode, input logic [1:0] ra, input logic [1:0] rb,
                          input logic [1:0] rd, input logic imm_sel, input logic [15:0] imm,
                          input logic cin_sel, input logic we);
    bus.cmd_mode    = mode;
    bus.cmd_ra      = ra;
    bus.cmd_rb      = rb;
    bus.cmd_rd      = rd;
    bus.cmd_imm_sel = imm_sel;
    bus.cmd_imm     = imm;
    bus.cmd_cin_sel = cin_sel;
    bus.cmd_we      = we;
    bus.cmd_valid   = 1'b1;
  endtask

  // One full command/result transaction, entered and left on a falling edge in IDLE.
  task automatic applyStimulus(input logic [3:0] mode, input logic [1:0] ra, input logic [1:0] rb,
                               input logic [1:0] rd, input logic imm_sel, input logic [15:0] imm,
                               input logic cin_sel, input logic we, input int stall, input logic early);
    logic [15:0] expA;
    logic [15:0] expB;
    logic        expCin;
    logic [17:0] r;
    expA   = modelRegs[ra];
    expB   = imm_sel ? imm : modelRegs[rb];
    expCin = cin_sel & modelC;
    r      = aluModel(expA, expB, mode, expCin);

    driveCmd(mode, ra, rb, rd, imm_sel, imm, cin_sel, we);
    checkOutput("cmd_ready_idle", bus.cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.res_ready = early;
    checkOutput("cmd_ready_exec", bus.cmd_ready, 0);
    checkOutput("res_valid_exec", bus.res_valid, 0);
    checkOutput("alu_A", bus.alu_A, expA);
    checkOutput("alu_B", bus.alu_B, expB);
    checkOutput("alu_Mode", bus.alu_Mode, mode);
    checkOutput("alu_Cin", bus.alu_Cin, expCin);

    @(posedge clk);
    @(negedge clk);
    if (we) modelRegs[rd] = r[15:0];
    if (mode == 4'd4 || mode == 4'd5) begin
      modelC = r[17];
      modelV = r[16];
    end
    checkOutput("res_valid", bus.res_valid, 1);
    checkOutput("res_data", bus.res_data, r[15:0]);
    checkOutput("res_cout", bus.res_cout, r[17]);
    checkOutput("res_ovf", bus.res_ovf, r[16]);
    checkOutput("flag_c", bus.flag_c, modelC);
    checkOutput("flag_v", bus.flag_v, modelV);

    if (stall > 0) begin
      bus.res_ready = 1'b0;
      driveCmd(~mode, ~ra, ~rb, ~rd, ~imm_sel, ~imm, ~cin_sel, ~we);
      repeat (stall) begin
        @(posedge clk);
        @(negedge clk);
        checkOutput("stall_res_valid", bus.res_valid, 1);
        checkOutput("stall_res_data", bus.res_data, r[15:0]);
        checkOutput("stall_cmd_ready", bus.cmd_ready, 0);
        checkOutput("stall_alu_Mode", bus.alu_Mode, mode);
        checkOutput("stall_alu_A", bus.alu_A, expA);
      end
      bus.cmd_valid = 1'b0;
    end

    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    checkOutput("done_res_valid", bus.res_valid, 0);
    checkOutput("done_cmd_ready", bus.cmd_ready, 1);
    checkOutput("done_alu_A_held", bus.alu_A, expA);
    checkOutput("done_res_data_held", bus.res_data, r[15:0]);
  endtask

  task automatic readReg(input logic [1:0] ra);
    applyStimulus(4'd15, ra, 2'd0, 2'd0, 1'b0, 16'd0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic loadImm(input logic [1:0] rd, input logic [15:0] imm);
    applyStimulus(4'd14, 2'd0, 2'd0, rd, 1'b1, imm, 1'b0, 1'b1, 0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    errorCount = 0;
    modelReset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b0;
    driveCmd(4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 16'd0, 1'b0, 1'b0);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("por");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("por_cmd_ready_after", bus.cmd_ready, 1);
    for (int i = 0; i < 4; i++) readReg(i[1:0]);

    // Add with signed overflow.
    loadImm(2'd0, 16'h7FFF);
    loadImm(2'd1, 16'h0001);
    applyStimulus(4'd4, 2'd0, 2'd1, 2'd2, 1'b0, 16'd0, 1'b0, 1'b1, 0, 1'b0);
    checkOutput("add_ovf_data", bus.res_data, 16'h8000);
    checkOutput("add_ovf_ovf", bus.res_ovf, 1);
    checkOutput("add_ovf_cout", bus.res_cout, 0);
    checkOutput("add_ovf_flag_v", bus.flag_v, 1);
    readReg(2'd2);
    checkOutput("add_ovf_r2", bus.res_data, 16'h8000);

    // Two-word carry chain.
    loadImm(2'd0, 16'hFFFF);
    loadImm(2'd1, 16'h0000);
    applyStimulus(4'd4, 2'd0, 2'd0, 2'd2, 1'b1, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
    checkOutput("chain_lo_data", bus.res_data, 16'h0000);
    checkOutput("chain_lo_c", bus.flag_c, 1);
    applyStimulus(4'd4, 2'd1, 2'd0, 2'd3, 1'b1, 16'h0000, 1'b1, 1'b1, 0, 1'b1);
    checkOutput("chain_hi_data", bus.res_data, 16'h0001);

    // Subtract, then a logic op must leave C untouched.
    loadImm(2'd0, 16'd5);
    applyStimulus(4'd5, 2'd0, 2'd0, 2'd1, 1'b1, 16'd3, 1'b0, 1'b1, 0, 1'b0);
    checkOutput("sub_data", bus.res_data, 16'h0002);
    checkOutput("sub_cout", bus.res_cout, 1);
    applyStimulus(4'd6, 2'd0, 2'd1, 2'd2, 1'b0, 16'd0, 1'b0, 1'b1, 0, 1'b0);
    checkOutput("and_keeps_c", bus.flag_c, 1);

    // Result backpressure, then back-to-back acceptance.
    applyStimulus(4'd8, 2'd0, 2'd1, 2'd3, 1'b0, 16'd0, 1'b0, 1'b1, 5, 1'b0);
    applyStimulus(4'd7, 2'd3, 2'd0, 2'd2, 1'b1, 16'h0F00, 1'b0, 1'b1, 0, 1'b0);

    // Compare without writeback.
    loadImm(2'd0, 16'd1);
    loadImm(2'd3, 16'h00AA);
    applyStimulus(4'd13, 2'd0, 2'd0, 2'd3, 1'b1, 16'd2, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("cmp_data", bus.res_data, 16'd1);
    readReg(2'd3);
    checkOutput("cmp_r3_kept", bus.res_data, 16'h00AA);

    // Randomized command stream.
    for (int n = 0; n < 60; n++) begin
      applyStimulus(4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom), 2'($urandom),
                    1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 2)), 1'($urandom));
    end
    for (int i = 0; i < 4; i++) readReg(i[1:0]);

    // Reset asserted mid-EXEC of a write to r3: discarded, nothing rises afterwards.
    loadImm(2'd0, 16'hFFFF);
    applyStimulus(4'd4, 2'd0, 2'd0, 2'd1, 1'b1, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
    driveCmd(4'd4, 2'd0, 2'd0, 2'd3, 1'b1, 16'h1234, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #2 rst = 1'b1;
    #1 checkResetOutputs("rst_exec");
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_exec_no_valid", bus.res_valid, 0);
    end
    readReg(2'd3);
    checkOutput("rst_exec_r3", bus.res_data, 16'd0);

    // Reset asserted mid-cycle while a result waits in RESP.
    loadImm(2'd2, 16'h8001);
    applyStimulus(4'd5, 2'd2, 2'd0, 2'd1, 1'b1, 16'h0002, 1'b0, 1'b1, 0, 1'b0);
    driveCmd(4'd4, 2'd2, 2'd2, 2'd0, 1'b0, 16'd0, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1 checkResetOutputs("rst_resp");
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    for (int i = 0; i < 4; i++) readReg(i[1:0]);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
